mem_arbiter: RTL and testbench

Shares the CPU's single multi-cycle unified memory between the I-cache miss path and the D-cache (write-through stores plus miss fills). It sits between the two cache controllers and the memory model. It grants one request at a time and streams 8-word block fills back into the requesting cache's data array. While it serves one side, the other side's pipeline stage stalls.

---
 rtl/cpu_mem_pkg.sv | 13 +
 rtl/blk_word_ctr.sv | 24 ++
 rtl/mem_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared types and block geometry for the unified-memory arbiter.
// Imported by the arbiter top and its word counter.
package cpu_mem_pkg;

  typedef enum logic [1:0] {IDLE, WR, ISSUE, DRAIN} state_t;
  typedef enum logic {SIDE_I, SIDE_D} side_t;

  localparam int BLK_WORDS    = 8;
  localparam int MEM_LAT      = 4;
  localparam int BLK_OFF_BITS = 4;
  localparam int WORD_IDX_W   = 3;

endpackage

// File: rtl/blk_word_ctr.sv
// Word index counter for one cache block: synchronous clear, enable and a last-word flag.
// It holds at the final word instead of wrapping, so a transfer can never alias word 0.
module blk_word_ctr
  import cpu_mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  output logic [WORD_IDX_W-1:0] cnt,
  output logic                  last
);

  assign last = (cnt == WORD_IDX_W'(BLK_WORDS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else if (en && !last) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single unified memory between I-cache fills and D-cache stores/fills,
// streaming each 8-word block fill back into the requesting cache's data array.
module mem_arbiter #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int BLK_WORDS = cpu_mem_pkg::BLK_WORDS,
  parameter int MEM_LAT   = cpu_mem_pkg::MEM_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_miss,
  input  logic [ADDR_W-1:0] i_miss_addr,
  input  logic              d_miss,
  input  logic [ADDR_W-1:0] d_miss_addr,
  input  logic              d_wr_req,
  input  logic [ADDR_W-1:0] d_wr_addr,
  input  logic [DATA_W-1:0] d_wr_data,
  output logic              d_wr_ack,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              fill_we_i,
  output logic              fill_we_d,
  output logic [2:0]        fill_word,
  output logic [DATA_W-1:0] fill_data,
  output logic              fill_done_i,
  output logic              fill_done_d,
  output logic              busy
);

  import cpu_mem_pkg::*;

  localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'((1 << BLK_OFF_BITS) - 1);

  if (BLK_WORDS != 8 || MEM_LAT < 1 || ADDR_W <= BLK_OFF_BITS) begin : g_param_check
    $error("mem_arbiter: needs BLK_WORDS == 8, MEM_LAT >= 1 and ADDR_W > BLK_OFF_BITS");
  end

  state_t            state;
  side_t             side;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic [2:0] issue_cnt;
  logic       issue_last;
  logic [2:0] recv_cnt;
  logic       recv_last;

  logic filling;
  logic word_valid;
  logic recv_done;

  assign filling    = (state == ISSUE) || (state == DRAIN);
  assign word_valid = filling && mem_rvalid;
  assign recv_done  = word_valid && recv_last;

  blk_word_ctr u_issue_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == IDLE),
    .en    (state == ISSUE),
    .cnt   (issue_cnt),
    .last  (issue_last)
  );

  blk_word_ctr u_recv_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == IDLE),
    .en    (word_valid),
    .cnt   (recv_cnt),
    .last  (recv_last)
  );

  // Control outputs are registered alongside the state so they carry no path from the requests.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      side     <= SIDE_I;
      base     <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      mem_en   <= 1'b0;
      mem_wr   <= 1'b0;
      d_wr_ack <= 1'b0;
      busy     <= 1'b0;
    end else begin
      d_wr_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (d_wr_req) begin
            state    <= WR;
            side     <= SIDE_D;
            wr_addr  <= d_wr_addr;
            wr_data  <= d_wr_data;
            mem_en   <= 1'b1;
            mem_wr   <= 1'b1;
            d_wr_ack <= 1'b1;
            busy     <= 1'b1;
          end else if (d_miss) begin
            state  <= ISSUE;
            side   <= SIDE_D;
            base   <= d_miss_addr & ~BLK_MASK;
            mem_en <= 1'b1;
            mem_wr <= 1'b0;
            busy   <= 1'b1;
          end else if (i_miss) begin
            state  <= ISSUE;
            side   <= SIDE_I;
            base   <= i_miss_addr & ~BLK_MASK;
            mem_en <= 1'b1;
            mem_wr <= 1'b0;
            busy   <= 1'b1;
          end
        end
        WR: begin
          state  <= IDLE;
          mem_en <= 1'b0;
          mem_wr <= 1'b0;
          busy   <= 1'b0;
        end
        ISSUE: begin
          if (recv_done) begin
            state  <= IDLE;
            mem_en <= 1'b0;
            busy   <= 1'b0;
          end else if (issue_last) begin
            state  <= DRAIN;
            mem_en <= 1'b0;
          end
        end
        DRAIN: begin
          if (recv_done) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          mem_en <= 1'b0;
          mem_wr <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == WR) begin
      mem_addr  = wr_addr;
      mem_wdata = wr_data;
    end else if (state == ISSUE) begin
      mem_addr = base | ADDR_W'({issue_cnt, 1'b0});
    end
  end

  // Returning words are forwarded in the same cycle they arrive; the last one also closes the fill.
  assign fill_we_i   = word_valid && (side == SIDE_I);
  assign fill_we_d   = word_valid && (side == SIDE_D);
  assign fill_word   = word_valid ? recv_cnt : '0;
  assign fill_data   = word_valid ? mem_rdata : '0;
  assign fill_done_i = fill_we_i && recv_last;
  assign fill_done_d = fill_we_d && recv_last;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency memory model returning addr ^ 0x5A5A.
// Cycle k of a transfer is the cycle in which the request is first seen in IDLE plus k.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_miss;
  logic [15:0] i_miss_addr;
  logic        d_miss;
  logic [15:0] d_miss_addr;
  logic        d_wr_req;
  logic [15:0] d_wr_addr;
  logic [15:0] d_wr_data;
  logic        d_wr_ack;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic        fill_we_i;
  logic        fill_we_d;
  logic [2:0]  fill_word;
  logic [15:0] fill_data;
  logic        fill_done_i;
  logic        fill_done_d;
  logic        busy;

  logic        stray;
  logic        pipe_v    [4];
  logic [15:0] pipe_addr [4];

  int checks_total  = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_miss      (i_miss),
    .i_miss_addr (i_miss_addr),
    .d_miss      (d_miss),
    .d_miss_addr (d_miss_addr),
    .d_wr_req    (d_wr_req),
    .d_wr_addr   (d_wr_addr),
    .d_wr_data   (d_wr_data),
    .d_wr_ack    (d_wr_ack),
    .mem_en      (mem_en),
    .mem_wr      (mem_wr),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_rvalid  (mem_rvalid),
    .fill_we_i   (fill_we_i),
    .fill_we_d   (fill_we_d),
    .fill_word   (fill_word),
    .fill_data   (fill_data),
    .fill_done_i (fill_done_i),
    .fill_done_d (fill_done_d),
    .busy        (busy)
  );

  // Memory model: a read issued in cycle n returns in cycle n+4; shares rst_n with the arbiter.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) pipe_v[i] <= 1'b0;
    end else begin
      pipe_v[0]    <= mem_en && !mem_wr;
      pipe_addr[0] <= mem_addr;
      for (int i = 1; i < 4; i++) begin
        pipe_v[i]    <= pipe_v[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
      end
    end
  end

  assign mem_rvalid = pipe_v[3] | stray;
  assign mem_rdata  = pipe_v[3] ? (pipe_addr[3] ^ 16'h5A5A) : 16'h0000;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_total++;
    if (got === exp) checks_passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    @(negedge clk);
    checkOutput({tag, ".busy"},      busy,        0);
    checkOutput({tag, ".mem_en"},    mem_en,      0);
    checkOutput({tag, ".mem_wr"},    mem_wr,      0);
    checkOutput({tag, ".mem_addr"},  mem_addr,    0);
    checkOutput({tag, ".mem_wdata"}, mem_wdata,   0);
    checkOutput({tag, ".ack"},       d_wr_ack,    0);
    checkOutput({tag, ".we_i"},      fill_we_i,   0);
    checkOutput({tag, ".we_d"},      fill_we_d,   0);
    checkOutput({tag, ".word"},      fill_word,   0);
    checkOutput({tag, ".data"},      fill_data,   0);
    checkOutput({tag, ".done_i"},    fill_done_i, 0);
    checkOutput({tag, ".done_d"},    fill_done_d, 0);
  endtask

  task automatic applyStimulus(input logic ireq, input logic [15:0] iaddr,
                               input logic dreq, input logic [15:0] daddr,
                               input logic wreq, input logic [15:0] waddr,
                               input logic [15:0] wdata);
    i_miss      = ireq;
    i_miss_addr = iaddr;
    d_miss      = dreq;
    d_miss_addr = daddr;
    d_wr_req    = wreq;
    d_wr_addr   = waddr;
    d_wr_data   = wdata;
  endtask

  // Expected timeline for a block fill: reads in 1..8, words in 5..12, done in 12, IDLE in 13.
  // Starts at the beginning of cycle first_k and returns at the beginning of cycle 14.
  task automatic expectFill(input string nm, input logic is_d, input logic [15:0] b,
                            input int first_k);
    logic [15:0] a;
    logic        in_words;
    for (int k = first_k; k <= 13; k++) begin
      @(negedge clk);
      in_words = (k >= 5 && k <= 12);
      checkOutput($sformatf("%s.busy.k%0d", nm, k),   busy,     (k >= 1 && k <= 12));
      checkOutput($sformatf("%s.mem_en.k%0d", nm, k), mem_en,   (k >= 1 && k <= 8));
      checkOutput($sformatf("%s.mem_wr.k%0d", nm, k), mem_wr,   0);
      checkOutput($sformatf("%s.ack.k%0d", nm, k),    d_wr_ack, 0);
      if (k >= 1 && k <= 8) begin
        a = b + 16'(2 * (k - 1));
        checkOutput($sformatf("%s.mem_addr.k%0d", nm, k), mem_addr, a);
      end
      checkOutput($sformatf("%s.we_i.k%0d", nm, k), fill_we_i, in_words && !is_d);
      checkOutput($sformatf("%s.we_d.k%0d", nm, k), fill_we_d, in_words && is_d);
      if (in_words) begin
        a = (b + 16'(2 * (k - 5))) ^ 16'h5A5A;
        checkOutput($sformatf("%s.word.k%0d", nm, k), fill_word, k - 5);
        checkOutput($sformatf("%s.data.k%0d", nm, k), fill_data, a);
      end
      checkOutput($sformatf("%s.done_i.k%0d", nm, k), fill_done_i, (k == 12) && !is_d);
      checkOutput($sformatf("%s.done_d.k%0d", nm, k), fill_done_d, (k == 12) && is_d);
      nextCycle();
      if (k == 12) begin
        if (is_d) d_miss = 1'b0;
        else      i_miss = 1'b0;
      end
    end
  endtask

  initial begin
    stray = 1'b0;
    rst_n = 1'b0;
    applyStimulus(1'b1, 16'h1111, 1'b1, 16'h2222, 1'b1, 16'h0A0A, 16'h1234);

    // Reset held for two cycles with every request high.
    nextCycle();
    checkAllZero("rst1");
    nextCycle();
    checkAllZero("rst2");
    nextCycle();
    rst_n = 1'b1;
    checkAllZero("rel0");
    nextCycle();
    @(negedge clk);
    checkOutput("rel1.ack",       d_wr_ack,  1);
    checkOutput("rel1.mem_en",    mem_en,    1);
    checkOutput("rel1.mem_wr",    mem_wr,    1);
    checkOutput("rel1.mem_addr",  mem_addr,  16'h0A0A);
    checkOutput("rel1.mem_wdata", mem_wdata, 16'h1234);
    checkOutput("rel1.busy",      busy,      1);
    nextCycle();
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    checkAllZero("rel2");
    nextCycle();

    // Plain I-cache fill.
    applyStimulus(1'b1, 16'h1234, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    expectFill("ifill", 1'b0, 16'h1230, 0);
    checkAllZero("ifill.after");
    nextCycle();

    // Contention: D wins, pending I enters ISSUE in cycle 14.
    applyStimulus(1'b1, 16'h2000, 1'b1, 16'h0040, 1'b0, 16'h0, 16'h0);
    expectFill("cont_d", 1'b1, 16'h0040, 0);
    expectFill("cont_i", 1'b0, 16'h2000, 1);
    nextCycle();

    // Store beats a D miss; the fill is seen in cycle 2 and issues from cycle 3.
    applyStimulus(1'b0, 16'h0, 1'b1, 16'h0306, 1'b1, 16'h0100, 16'hBEEF);
    @(negedge clk);
    checkOutput("st.k0.busy", busy, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("st.k1.ack",       d_wr_ack,  1);
    checkOutput("st.k1.mem_en",    mem_en,    1);
    checkOutput("st.k1.mem_wr",    mem_wr,    1);
    checkOutput("st.k1.mem_addr",  mem_addr,  16'h0100);
    checkOutput("st.k1.mem_wdata", mem_wdata, 16'hBEEF);
    checkOutput("st.k1.we_d",      fill_we_d, 0);
    nextCycle();
    d_wr_req = 1'b0;
    expectFill("st_fill", 1'b1, 16'h0300, 0);
    nextCycle();

    // Abort a fill with reset in cycle 6, then run a fresh fill.
    applyStimulus(1'b1, 16'h0A00, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    for (int k = 0; k < 6; k++) nextCycle();
    rst_n  = 1'b0;
    i_miss = 1'b0;
    @(negedge clk);
    checkOutput("abort.k6.we_i", fill_we_i, 1);
    checkOutput("abort.k6.word", fill_word, 1);
    nextCycle();
    rst_n = 1'b1;
    checkAllZero("abort.k7");
    for (int k = 8; k <= 12; k++) begin
      nextCycle();
      checkAllZero($sformatf("abort.k%0d", k));
    end
    nextCycle();
    applyStimulus(1'b1, 16'h0C02, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    expectFill("refill", 1'b0, 16'h0C00, 0);
    nextCycle();

    // Stray rvalid in IDLE must not write or advance the receive count.
    stray = 1'b1;
    checkAllZero("stray");
    nextCycle();
    stray = 1'b0;
    applyStimulus(1'b1, 16'h3456, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    expectFill("post_stray", 1'b0, 16'h3450, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
